// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared types and helpers for the cache miss-handling slice.
//   victim_state_t : phases of the victim/eviction controller
//   beat_w()       : width of a beat index for a line of BEATS bus beats
// ---------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WRITEBACK,
    FILL,
    COMMIT
  } victim_state_t;

  // BEATS is a power of two >= 2, so clog2 gives an index that wraps exactly
  // at the end of a line. Clamp to 1 so a degenerate value still elaborates.
  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/cache_victim_fsm_if.sv
// ---------------------------------------------------------------------------
// cache_victim_fsm_if
// Bundles the miss request, replacement-unit, valid-array and bus signals of
// the victim controller.
//   master : the controller (cache_victim_fsm)
//   slave  : the surrounding cache, replacement unit and bus interface
// Inputs to the controller : MissReq, MissSet, VictimWay, VictimDirty,
//                            FlushStage, BusReady
// Outputs of the controller: BusValid, BusWrite, BeatIdx, SelWay, SelSet,
//                            ClearValid, SetValid, LFSRWriteEn, MissDone
// ---------------------------------------------------------------------------
interface cache_victim_fsm_if
  import cache_pkg::*;
#(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 7,
  parameter int BEATS   = 4
);

  localparam int BW = beat_w(BEATS);

  logic               MissReq;
  logic [SETLEN-1:0]  MissSet;
  logic [NUMWAYS-1:0] VictimWay;
  logic               VictimDirty;
  logic               FlushStage;
  logic               BusReady;

  logic               BusValid;
  logic               BusWrite;
  logic [BW-1:0]      BeatIdx;
  logic [NUMWAYS-1:0] SelWay;
  logic [SETLEN-1:0]  SelSet;
  logic               ClearValid;
  logic               SetValid;
  logic               LFSRWriteEn;
  logic               MissDone;

  modport master (
    input  MissReq, MissSet, VictimWay, VictimDirty, FlushStage, BusReady,
    output BusValid, BusWrite, BeatIdx, SelWay, SelSet,
           ClearValid, SetValid, LFSRWriteEn, MissDone
  );

  modport slave (
    output MissReq, MissSet, VictimWay, VictimDirty, FlushStage, BusReady,
    input  BusValid, BusWrite, BeatIdx, SelWay, SelSet,
           ClearValid, SetValid, LFSRWriteEn, MissDone
  );

endinterface

// File: rtl/cache_beat_ctr.sv
// ---------------------------------------------------------------------------
// cache_beat_ctr
// Beat counter for one cache-line burst; shared by writeback and fill.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the index back to 0
//   en         : a beat was accepted this cycle; advance the index
//   idx        : current beat index (wraps modulo BEATS)
//   last       : current beat is the final beat of the line
// ---------------------------------------------------------------------------
module cache_beat_ctr
  import cache_pkg::*;
#(
  parameter int BEATS = 4,
  localparam int W = beat_w(BEATS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         last
);

  logic [W-1:0] idx_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (en) begin
      // BEATS is a power of two, so the natural overflow is the wrap to 0
      // that leaves the counter ready for the next phase.
      idx_q <= idx_q + W'(1);
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == W'(BEATS - 1));

endmodule

// File: rtl/cache_victim_fsm.sv
// ---------------------------------------------------------------------------
// cache_victim_fsm
// Miss-handling controller: latches the replacement unit's victim way and the
// miss set, writes the victim line back when dirty, fetches the new line,
// sets its valid bit and pulses the replacement unit's update enable.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : cache_victim_fsm_if.master (miss request, victim, valid-array
//             control and bus beat handshake)
// ---------------------------------------------------------------------------
module cache_victim_fsm
  import cache_pkg::*;
#(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 7,
  parameter int BEATS   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cache_victim_fsm_if.master    bus
);

  localparam int BW = beat_w(BEATS);

  victim_state_t       state_q;
  logic [NUMWAYS-1:0]  sel_way_q;
  logic [SETLEN-1:0]   sel_set_q;
  logic                bus_valid_q;
  logic                bus_write_q;   // doubles as the latched dirty flag
  logic                clear_q;       // high throughout CAPTURE
  logic                commit_q;      // high throughout COMMIT

  logic [BW-1:0]       beat_idx;
  logic                beat_last;
  logic                beat_fire;
  logic                beat_clr;

  // A beat moves only while a request is outstanding and the bus takes it.
  assign beat_fire = bus_valid_q & bus.BusReady;
  assign beat_clr  = (state_q == CAPTURE);

  cache_beat_ctr #(.BEATS(BEATS)) u_beat_ctr (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (beat_clr),
    .en    (beat_fire),
    .idx   (beat_idx),
    .last  (beat_last)
  );

  // Outputs are registered alongside the state: each is set on the edge that
  // enters the state it belongs to, so they line up exactly with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel_way_q   <= '0;
      sel_set_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_write_q <= 1'b0;
      clear_q     <= 1'b0;
      commit_q    <= 1'b0;
    end else begin
      clear_q  <= 1'b0;
      commit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.MissReq && !bus.FlushStage) begin
            state_q <= CAPTURE;
            clear_q <= 1'b1;
          end
        end
        CAPTURE: begin
          if (bus.FlushStage) begin
            // Squashed miss: nothing latched, nothing started.
            state_q <= IDLE;
          end else begin
            sel_way_q   <= bus.VictimWay;
            sel_set_q   <= bus.MissSet;
            bus_valid_q <= 1'b1;
            bus_write_q <= bus.VictimDirty;
            state_q     <= bus.VictimDirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          // BusValid stays high across the phase change: writeback and fill
          // form one uninterrupted request stream.
          if (beat_fire && beat_last) begin
            bus_write_q <= 1'b0;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (beat_fire && beat_last) begin
            bus_valid_q <= 1'b0;
            commit_q    <= 1'b1;
            state_q     <= COMMIT;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.BusValid    = bus_valid_q;
  assign bus.BusWrite    = bus_write_q;
  assign bus.BeatIdx     = beat_idx;
  assign bus.SelWay      = sel_way_q;
  assign bus.SelSet      = sel_set_q;
  // A flush arriving in CAPTURE squashes the miss, so the valid bit must not
  // be cleared in that same cycle; the gate has to be combinational.
  assign bus.ClearValid  = clear_q & ~bus.FlushStage;
  assign bus.SetValid    = commit_q;
  assign bus.MissDone    = commit_q;
  // The line is still installed on a flush, but the replacement state must
  // not advance for a squashed access.
  assign bus.LFSRWriteEn = commit_q & ~bus.FlushStage;

endmodule

// File: tb/tb_cache_victim_fsm.sv
// ---------------------------------------------------------------------------
// tb_cache_victim_fsm
// Self-checking bench for cache_victim_fsm. Each miss is expanded by the bench
// into its expected cycle sequence (idle, capture, writeback beats, fill
// beats, commit) and every cycle's outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_cache_victim_fsm;

  localparam int NUMWAYS = 4;
  localparam int SETLEN  = 7;
  localparam int BEATS   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  cache_victim_fsm_if #(.NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .BEATS(BEATS)) bus ();

  cache_victim_fsm #(.NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .BEATS(BEATS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expected contents of the victim latch.
  logic [NUMWAYS-1:0] exp_sel_way = '0;
  logic [SETLEN-1:0]  exp_sel_set = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_outs(input string tag, input logic bv, input logic bw, input int idx,
                            input logic cv, input logic sv, input logic md, input logic lf);
    check({tag, ".BusValid"},    32'(bus.BusValid),    32'(bv));
    check({tag, ".BusWrite"},    32'(bus.BusWrite),    32'(bw));
    check({tag, ".BeatIdx"},     32'(bus.BeatIdx),     32'(idx));
    check({tag, ".ClearValid"},  32'(bus.ClearValid),  32'(cv));
    check({tag, ".SetValid"},    32'(bus.SetValid),    32'(sv));
    check({tag, ".MissDone"},    32'(bus.MissDone),    32'(md));
    check({tag, ".LFSRWriteEn"}, 32'(bus.LFSRWriteEn), 32'(lf));
    check({tag, ".SelWay"},      32'(bus.SelWay),      32'(exp_sel_way));
    check({tag, ".SelSet"},      32'(bus.SelSet),      32'(exp_sel_set));
  endtask

  function automatic logic [NUMWAYS-1:0] rand_way();
    return NUMWAYS'(1) << $urandom_range(0, NUMWAYS - 1);
  endfunction

  // One complete miss. Inputs are driven on the falling edge and outputs are
  // checked 1 time unit later, well away from the rising edge.
  //   stall_mode : 0 = BusReady always 1, 1 = 1,0,1,0..., 2 = random stalls
  //   reset_beat : writeback beat at which reset is pulsed (-1 = never)
  //   hold_req   : keep MissReq high after COMMIT to start the next miss
  task automatic run_miss(input logic [NUMWAYS-1:0] way, input logic dirty,
                          input int stall_mode, input bit flush_cap,
                          input bit flush_commit, input bit change_victim,
                          input int reset_beat, input bit hold_req);
    logic [SETLEN-1:0] set;
    bit ready;
    int toggle;
    set    = SETLEN'($urandom);
    toggle = 0;

    // IDLE: request sampled on the following edge.
    @(negedge clk);
    bus.MissReq     = 1'b1;
    bus.MissSet     = set;
    bus.FlushStage  = 1'b0;
    bus.BusReady    = 1'($urandom);
    bus.VictimWay   = rand_way();
    bus.VictimDirty = 1'($urandom);
    #1 check_outs("idle", 0, 0, 0, 0, 0, 0, 0);

    // CAPTURE: victim and dirty flag are valid here.
    @(negedge clk);
    bus.VictimWay   = way;
    bus.VictimDirty = dirty;
    bus.FlushStage  = flush_cap;
    #1 check_outs("capture", 0, 0, 0, !flush_cap, 0, 0, 0);

    if (flush_cap) begin
      @(negedge clk);
      bus.MissReq    = 1'b0;
      bus.FlushStage = 1'b0;
      #1 check_outs("flushed", 0, 0, 0, 0, 0, 0, 0);
      return;
    end
    exp_sel_way = way;
    exp_sel_set = set;

    // Bus phases: writeback (dirty only) then fill, BEATS accepted beats each.
    for (int ph = (dirty ? 0 : 1); ph < 2; ph++) begin
      for (int b = 0; b < BEATS; b++) begin
        int stalls;
        stalls = 0;
        do begin
          @(negedge clk);
          case (stall_mode)
            0:       ready = 1'b1;
            1:       ready = (toggle % 2 == 0);
            default: ready = ($urandom_range(0, 2) != 0) || (stalls >= 3);
          endcase
          toggle++;
          if (!ready) stalls++;
          bus.BusReady    = ready;
          bus.FlushStage  = ($urandom_range(0, 3) == 0);
          bus.VictimDirty = 1'($urandom);
          if (change_victim && ph == 1) bus.VictimWay = NUMWAYS'(1);
          #1 check_outs(ph == 0 ? "wb" : "fill", 1, (ph == 0), b, 0, 0, 0, 0);
          if (ph == 0 && b == reset_beat) begin
            // Asynchronous reset in the middle of the cycle.
            #2 reset_n = 1'b0;
            exp_sel_way = '0;
            exp_sel_set = '0;
            #1 check_outs("mid_reset", 0, 0, 0, 0, 0, 0, 0);
            bus.MissReq = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            return;
          end
        end while (!ready);
      end
    end

    // COMMIT
    @(negedge clk);
    bus.FlushStage = flush_commit;
    bus.BusReady   = 1'($urandom);
    #1 check_outs("commit", 0, 0, 0, 0, 1, 1, !flush_commit);

    if (!hold_req) begin
      @(negedge clk);
      bus.MissReq    = 1'b0;
      bus.FlushStage = 1'b0;
      #1 check_outs("post", 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.MissReq     = 1'b0;
    bus.MissSet     = '0;
    bus.VictimWay   = '0;
    bus.VictimDirty = 1'b0;
    bus.FlushStage  = 1'b0;
    bus.BusReady    = 1'b0;

    #12 check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Clean miss, no stalls: fixed victim way.
    run_miss(4'b0100, 1'b0, 0, 0, 0, 0, -1, 0);
    // Dirty miss with BusReady toggling 1,0,1,...
    run_miss(rand_way(), 1'b1, 1, 0, 0, 0, -1, 0);
    // Flush during CAPTURE squashes the miss; SelWay keeps its old value.
    run_miss(4'b0010, 1'b1, 0, 1, 0, 0, -1, 0);
    // Flush during COMMIT suppresses only LFSRWriteEn.
    run_miss(rand_way(), 1'b0, 0, 0, 1, 0, -1, 0);
    // Victim changes mid-fill must not reach SelWay.
    run_miss(4'b0100, 1'b0, 2, 0, 0, 1, -1, 0);
    // Reset at writeback beat 2, then a clean miss starting from beat 0.
    run_miss(rand_way(), 1'b1, 0, 0, 0, 0, 2, 0);
    run_miss(rand_way(), 1'b0, 0, 0, 0, 0, -1, 0);
    // Back-to-back misses with MissReq held through COMMIT.
    run_miss(rand_way(), 1'b1, 0, 0, 0, 0, -1, 1);
    run_miss(rand_way(), 1'b0, 0, 0, 0, 0, -1, 0);

    // Randomized misses.
    for (int i = 0; i < 40; i++) begin
      run_miss(rand_way(), 1'($urandom), $urandom_range(0, 2),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
               1'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(0, BEATS - 1) : -1,
               1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
